// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
package hazard_ctrl_pkg;

   localparam int REG_W = 3;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(
   parameter int CNT_W = 16
) ();

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_rs_valid;
   logic             id_rt_valid;
   logic [REG_W-1:0] ex_write_reg;
   logic             ex_write_reg_valid;
   logic             ex_mem_read;
   logic             ex_redirect;
   logic             ex_halt;
   logic             dmem_busy;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             control_zero_idex;
   logic             pipe_freeze;
   logic             halt_done;
   logic [CNT_W-1:0] stall_cnt;

   // pipeline datapath side
   modport master (
      output id_rs, id_rt, id_rs_valid, id_rt_valid,
      output ex_write_reg, ex_write_reg_valid, ex_mem_read,
      output ex_redirect, ex_halt, dmem_busy,
      input  pc_write, ifid_write, ifid_flush, control_zero_idex,
      input  pipe_freeze, halt_done, stall_cnt
   );

   // hazard controller side
   modport slave (
      input  id_rs, id_rt, id_rs_valid, id_rt_valid,
      input  ex_write_reg, ex_write_reg_valid, ex_mem_read,
      input  ex_redirect, ex_halt, dmem_busy,
      output pc_write, ifid_write, ifid_flush, control_zero_idex,
      output pipe_freeze, halt_done, stall_cnt
   );

endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// rtl/hazard_ctrl_hazard_detect.sv - load-use comparator between ID sources and ID/EX load target
module hazard_detect import hazard_ctrl_pkg::*; (
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_rs_valid_i,
   input  logic             id_rt_valid_i,
   input  logic [REG_W-1:0] ex_write_reg_i,
   input  logic             ex_write_reg_valid_i,
   input  logic             ex_mem_read_i,
   output logic             load_use_o
);

   logic rs_hit;
   logic rt_hit;

   // R0 is not special-cased; the decoder clears the valid bits instead
   always_comb begin
      rs_hit     = id_rs_valid_i & (id_rs_i == ex_write_reg_i);
      rt_hit     = id_rt_valid_i & (id_rt_i == ex_write_reg_i);
      load_use_o = ex_mem_read_i & ex_write_reg_valid_i & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze sequencing and halt drain
module hazard_ctrl import hazard_ctrl_pkg::*; #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam logic [7:0] DRAIN_CNT = 8'(DRAIN_CYCLES);

   state_e           state_q, state_d;
   logic [7:0]       drain_q, drain_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic pc_write;
   logic ifid_write;
   logic ifid_flush;
   logic control_zero_idex;
   logic pipe_freeze;
   logic halt_done;

   hazard_detect u_detect (
      .id_rs_i              (hz.id_rs),
      .id_rt_i              (hz.id_rt),
      .id_rs_valid_i        (hz.id_rs_valid),
      .id_rt_valid_i        (hz.id_rt_valid),
      .ex_write_reg_i       (hz.ex_write_reg),
      .ex_write_reg_valid_i (hz.ex_write_reg_valid),
      .ex_mem_read_i        (hz.ex_mem_read),
      .load_use_o           (load_use)
   );

   // state, drain counter and stall counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         drain_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // next state; a halt only wins when no redirect squashes it in the same cycle
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (hz.dmem_busy) begin
               state_d = MEM_WAIT;
            end else if (!hz.ex_redirect && hz.ex_halt) begin
               state_d = DRAIN;
               drain_d = 8'd1;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            // a stalled memory stage has not retired anything, so the count pauses
            if (!hz.dmem_busy) begin
               if (drain_q == DRAIN_CNT) state_d = HALTED;
               else                      drain_d = drain_q + 8'd1;
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = RUN;
      endcase
      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // pipeline control outputs from state and current hazards
   always_comb begin
      pc_write          = 1'b1;
      ifid_write        = 1'b1;
      ifid_flush        = 1'b0;
      control_zero_idex = 1'b0;
      pipe_freeze       = 1'b0;
      halt_done         = 1'b0;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (hz.dmem_busy) begin
               pipe_freeze = 1'b1;
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
            end else if (hz.ex_redirect) begin
               ifid_flush        = 1'b1;
               control_zero_idex = 1'b1;
            end else if (hz.ex_halt || load_use) begin
               pc_write          = 1'b0;
               ifid_write        = 1'b0;
               control_zero_idex = 1'b1;
            end
         end
         DRAIN: begin
            pc_write          = 1'b0;
            ifid_write        = 1'b0;
            control_zero_idex = 1'b1;
            pipe_freeze       = hz.dmem_busy;
         end
         default: begin
            halt_done         = 1'b1;
            pc_write          = 1'b0;
            ifid_write        = 1'b0;
            control_zero_idex = 1'b1;
         end
      endcase
   end

   assign hz.pc_write          = pc_write;
   assign hz.ifid_write        = ifid_write;
   assign hz.ifid_flush        = ifid_flush;
   assign hz.control_zero_idex = control_zero_idex;
   assign hz.pipe_freeze       = pipe_freeze;
   assign hz.halt_done         = halt_done;
   assign hz.stall_cnt         = stall_cnt_q;

endmodule
